uart_rx_fsm: RTL and testbench

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// Receive-side control for an 8x oversampled UART. The FSM walks one frame
// (start, DATA_WIDTH data bits LSB first, optional parity, stop), samples
// each bit three times around its centre and votes. Frames with a correct
// stop bit and correct parity update p_data. Bad frames pulse an error
// output instead.
//
// The oversample/bit counter lives outside this block. It is held clear
// while cnt_enable is low. It free-runs while cnt_enable is high: edge_cnt
// counts 0..7 and bit_cnt steps on the cycle after edge_cnt==7.
//
// Ports
//   clk         in   rising-edge clock, 8x the bit rate
//   rst         in   synchronous active-high reset
//   rx_in       in   serial line, idle high, already synchronised to clk
//   par_en      in   1 = parity bit follows the data bits
//   par_typ     in   0 = even parity, 1 = odd parity
//   edge_cnt    in   [2:0] oversample position inside the current bit
//   bit_cnt     in   [3:0] bit index inside the current frame
//   cnt_enable  out  runs the external counter; low clears it
//   p_data      out  [DATA_WIDTH-1:0] last error-free received word
//   data_valid  out  one-cycle pulse when p_data has been updated
//   par_err     out  one-cycle pulse, parity mismatch on the finished frame
//   stp_err     out  one-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [2:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [3:0] LP_LAST_BIT = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    logic [2:0]            r_samples;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_pData;
    logic                  r_parEn;
    logic                  r_parTyp;
    logic                  r_parFlag;
    logic                  r_stpFlag;
    logic                  r_dataValid;
    logic                  r_parErr;
    logic                  r_stpErr;

    logic                  w_majority;
    logic                  w_parExpected;
    logic                  w_edge6;
    logic                  w_edge7;
    logic                  w_startFrame;
    logic                  w_shiftEn;
    logic                  w_parFlagSet;
    logic                  w_stpFlagSet;
    logic                  w_frameEnd;

    // The three centre samples are registered at edge_cnt 3, 4 and 5, so the
    // vote is stable from edge_cnt 6 onwards. Deciding at 6 leaves edge_cnt 7
    // free for the state change, which keeps the decision and the move apart.
    assign w_majority    = (r_samples[0] & r_samples[1]) |
                           (r_samples[0] & r_samples[2]) |
                           (r_samples[1] & r_samples[2]);
    assign w_parExpected = (^r_shift) ^ r_parTyp;
    assign w_edge6       = (edge_cnt == 3'd6);
    assign w_edge7       = (edge_cnt == 3'd7);

    assign cnt_enable    = (r_state != IDLE);
    assign p_data        = r_pData;
    assign data_valid    = r_dataValid;
    assign par_err       = r_parErr;
    assign stp_err       = r_stpErr;

    // State register. Reset wins over any transition computed for this cycle,
    // so a frame aborted by reset never reaches STOP and never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and datapath-control decode. Every bit decision happens at
    // edge_cnt 6 and every move between bits at edge_cnt 7. The one exception
    // is a false start, which leaves START straight from edge_cnt 6 so the
    // line is watched again as soon as possible. A bit_cnt beyond the frame
    // length while in DATA means the counter and FSM have lost step. The
    // frame is dropped silently rather than finishing on a bad count.
    always_comb begin
        w_nextState  = r_state;
        w_startFrame = 1'b0;
        w_shiftEn    = 1'b0;
        w_parFlagSet = 1'b0;
        w_stpFlagSet = 1'b0;
        w_frameEnd   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rx_in) begin
                    w_nextState  = START;
                    w_startFrame = 1'b1;
                end
            end
            START: begin
                if (w_edge6 && w_majority) begin
                    w_nextState = IDLE;
                end else if (w_edge7) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (bit_cnt > LP_LAST_BIT) begin
                    w_nextState = IDLE;
                end else begin
                    if (w_edge6) begin
                        w_shiftEn = 1'b1;
                    end
                    if (w_edge7 && (bit_cnt == LP_LAST_BIT)) begin
                        w_nextState = r_parEn ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_edge6 && (w_majority != w_parExpected)) begin
                    w_parFlagSet = 1'b1;
                end
                if (w_edge7) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_edge6 && !w_majority) begin
                    w_stpFlagSet = 1'b1;
                end
                if (w_edge7) begin
                    w_nextState = IDLE;
                    w_frameEnd  = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Centre sampler. The counter sits at 0 whenever the FSM is idle, so
    // these only ever load while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_samples <= '0;
        end else begin
            if (edge_cnt == 3'd3) begin
                r_samples[0] <= rx_in;
            end
            if (edge_cnt == 3'd4) begin
                r_samples[1] <= rx_in;
            end
            if (edge_cnt == 3'd5) begin
                r_samples[2] <= rx_in;
            end
        end
    end

    // Frame configuration and error flags. Parity settings are captured on
    // the edge that detects the start bit, so a host changing them mid-frame
    // cannot corrupt the frame already in flight. The flags are cleared on
    // that same edge, so each frame is judged only on its own bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parEn   <= 1'b0;
            r_parTyp  <= 1'b0;
            r_parFlag <= 1'b0;
            r_stpFlag <= 1'b0;
        end else if (w_startFrame) begin
            r_parEn   <= par_en;
            r_parTyp  <= par_typ;
            r_parFlag <= 1'b0;
            r_stpFlag <= 1'b0;
        end else begin
            if (w_parFlagSet) begin
                r_parFlag <= 1'b1;
            end
            if (w_stpFlagSet) begin
                r_stpFlag <= 1'b1;
            end
        end
    end

    // Data shift register. Bits arrive LSB first, so each new bit enters at
    // the top and moves down. After DATA_WIDTH shifts, the first bit
    // received sits in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if (w_shiftEn) begin
            r_shift <= {w_majority, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Frame result. On the edge that leaves STOP, a clean frame publishes
    // the word and pulses data_valid. A flagged frame pulses only its error
    // outputs and leaves the last good word on p_data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pData     <= '0;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
        end else begin
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
            if (w_frameEnd) begin
                if (!r_parFlag && !r_stpFlag) begin
                    r_dataValid <= 1'b1;
                    r_pData     <= r_shift;
                end else begin
                    r_parErr <= r_parFlag;
                    r_stpErr <= r_stpFlag;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
//
// Drives serial frames into uart_rx_fsm. It models the external edge/bit
// counter from its contract. Expected pulses (kind, p_data, cycle) are
// queued when each frame is launched. A monitor pops them whenever the DUT
// raises data_valid, par_err or stp_err.
//
// Cycle numbering: cyc counts rising edges, and "cycle n" is the interval
// after the n-th edge. When the line is driven low during cycle c, the FSM
// sees it at edge c+1, so START begins at T = c+1. The result pulse shows
// up during cycle T+80, or T+88 when a parity bit is present.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int DW         = 8;
    localparam int KIND_VALID = 0;
    localparam int KIND_PAR   = 1;
    localparam int KIND_STP   = 2;

    typedef struct {
        int kind;
        int data;
        int cycle;
    } expect_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          par_en;
    logic          par_typ;
    logic [2:0]    edge_cnt = '0;
    logic [3:0]    bitModel = '0;
    logic [3:0]    bitOffset;
    logic [3:0]    bit_cnt;
    logic          cnt_enable;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            lastGood = 0;
    int            tStart   = 0;
    int            monKind  = 0;
    expect_t       monExp;
    expect_t       sbQueue[$];

    uart_rx_fsm #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .cnt_enable (cnt_enable),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    // Clock and rising-edge count used to time-stamp every pulse.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Edge/bit counter behaving exactly as its contract describes. bitOffset
    // lets a test push bit_cnt out of range on purpose.
    always @(posedge clk) begin
        if (!cnt_enable) begin
            edge_cnt <= 3'd0;
            bitModel <= 4'd0;
        end else begin
            edge_cnt <= edge_cnt + 3'd1;
            if (edge_cnt == 3'd7) begin
                bitModel <= bitModel + 4'd1;
            end
        end
    end

    assign bit_cnt = bitModel + bitOffset;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                     name, actual, actual, required, required, cyc);
        end
    endtask

    task automatic expectPulse(input int kind, input int data, input int cycle);
        expect_t e;
        e.kind  = kind;
        e.data  = data;
        e.cycle = cycle;
        sbQueue.push_back(e);
    endtask

    task automatic sendBit(input logic b);
        rx_in = b;
        repeat (8) @(negedge clk);
    endtask

    // One complete frame on the line, launched from a falling edge.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic hasPar,
                                 input logic parBit, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < DW; i++) begin
            sendBit(data[i]);
        end
        if (hasPar) begin
            sendBit(parBit);
        end
        sendBit(stopBit);
        rx_in = 1'b1;
    endtask

    // Monitor. Checks each output pulse against the oldest queued
    // expectation. A pulse with nothing queued is a failure by itself.
    always @(negedge clk) begin
        if (data_valid || par_err || stp_err) begin
            monKind = data_valid ? KIND_VALID : (par_err ? KIND_PAR : KIND_STP);
            checkOutput("pulse_exclusive", int'(data_valid) + int'(par_err) + int'(stp_err), 1);
            if (sbQueue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pulse: got kind %0d p_data 0x%0h at cycle %0d, required no pulse",
                         monKind, p_data, cyc);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("pulse_kind", monKind, monExp.kind);
                checkOutput("pulse_p_data", int'(p_data), monExp.data);
                checkOutput("pulse_cycle", cyc, monExp.cycle);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        rx_in     = 1'b1;
        par_en    = 1'b0;
        par_typ   = 1'b0;
        bitOffset = 4'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_cnt_enable", int'(cnt_enable), 0);
        checkOutput("reset_p_data", int'(p_data), 0);
        checkOutput("reset_data_valid", int'(data_valid), 0);
        checkOutput("reset_par_err", int'(par_err), 0);
        checkOutput("reset_stp_err", int'(stp_err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_line_high", int'(cnt_enable), 0);

        // 0xA5 without parity. par_en/par_typ are flipped mid-frame and must
        // not change this frame's shape.
        $display("[TB] frame 0xA5, no parity");
        tStart = cyc + 1;
        expectPulse(KIND_VALID, 'hA5, tStart + 80);
        lastGood = 'hA5;
        fork
            applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge clk);
                par_en  = 1'b1;
                par_typ = 1'b1;
            end
        join
        repeat (6) @(negedge clk);

        // Even parity, 0x07 has three ones, so parity bit 0 is wrong.
        $display("[TB] frame 0x07, even parity, bad parity bit");
        par_en  = 1'b1;
        par_typ = 1'b0;
        tStart  = cyc + 1;
        expectPulse(KIND_PAR, lastGood, tStart + 88);
        applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // Same byte with the correct even parity bit.
        $display("[TB] frame 0x07, even parity, good parity bit");
        tStart = cyc + 1;
        expectPulse(KIND_VALID, 'h07, tStart + 88);
        lastGood = 'h07;
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);

        // Odd parity, 0x81 has two ones, so the correct parity bit is 1.
        $display("[TB] frame 0x81, odd parity, good parity bit");
        par_typ = 1'b1;
        tStart  = cyc + 1;
        expectPulse(KIND_VALID, 'h81, tStart + 88);
        lastGood = 'h81;
        applyStimulus(8'h81, 1'b1, 1'b1, 1'b1);
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (6) @(negedge clk);

        // Two-cycle glitch. Still in START at T+6, back in IDLE at T+7.
        $display("[TB] start glitch");
        tStart = cyc + 1;
        rx_in  = 1'b0;
        repeat (2) @(negedge clk);
        rx_in  = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("glitch_start_at_t6", cyc - tStart, 6);
        checkOutput("glitch_busy_at_t6", int'(cnt_enable), 1);
        @(negedge clk);
        checkOutput("glitch_idle_at_t7", int'(cnt_enable), 0);
        repeat (10) @(negedge clk);

        // Stop bit low gives stp_err at T+80 and p_data keeps 0x81.
        $display("[TB] frame 0x5A, stop bit low");
        tStart = cyc + 1;
        expectPulse(KIND_STP, lastGood, tStart + 80);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        // Back-to-back frames. The second start bit begins in STOP's last
        // cycle. The FSM sees it in the IDLE cycle right after, so the
        // second START is at T+81 and its pulse is at T+161.
        $display("[TB] back-to-back frames 0x3C, 0xC3");
        tStart = cyc + 1;
        expectPulse(KIND_VALID, 'h3C, tStart + 80);
        expectPulse(KIND_VALID, 'hC3, tStart + 81 + 80);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1);
        lastGood = 'hC3;
        repeat (6) @(negedge clk);

        // Reset seen at edge T+40 while in DATA. The remaining bits of 0xFF
        // keep the line high, so nothing restarts afterwards.
        $display("[TB] reset mid-frame");
        tStart = cyc + 1;
        fork
            applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                checkOutput("busy_before_reset", int'(cnt_enable), 1);
                rst = 1'b1;
                @(negedge clk);
                checkOutput("reset_mid_cycle", cyc - tStart, 40);
                checkOutput("reset_mid_cnt_enable", int'(cnt_enable), 0);
                checkOutput("reset_mid_p_data", int'(p_data), 0);
                rst = 1'b0;
            end
        join
        lastGood = 0;
        repeat (6) @(negedge clk);
        checkOutput("idle_after_reset_frame", int'(cnt_enable), 0);

        $display("[TB] frame 0x96 after reset");
        tStart = cyc + 1;
        expectPulse(KIND_VALID, 'h96, tStart + 80);
        lastGood = 'h96;
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);

        // bit_cnt pushed past the frame length during DATA drops the frame.
        $display("[TB] out-of-range bit_cnt");
        tStart = cyc + 1;
        fork
            applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge clk);
                checkOutput("busy_before_bad_count", int'(cnt_enable), 1);
                bitOffset = 4'd8;
                @(negedge clk);
                checkOutput("bad_count_idle", int'(cnt_enable), 0);
                bitOffset = 4'd0;
            end
        join
        repeat (20) @(negedge clk);
        checkOutput("p_data_held_at_end", int'(p_data), lastGood);
        checkOutput("scoreboard_drained", sbQueue.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
